// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller oversampling the JTAG pins in the clk domain
// Ports:
//   clk, rstn                 system clock, asynchronous active-low reset
//   tck, tms, tdi, trstn      raw JTAG pins, asynchronous to clk
//   tdo, tdo_en               test data out and its shift-valid flag
//   tap_state                 current TAP state (1149.1 encoding)
//   ir                        current instruction (1 = IDCODE, 2 = USER, else BYPASS)
//   user_capture_data         loaded into the user DR on Capture-DR
//   user_update_data          user DR contents latched on Update-DR
//   user_update               one-clk pulse when user_update_data is loaded
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH      = 5,
    parameter logic [31:0] IDCODE        = 32'h1DC0_0001,
    parameter int          USER_DR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     tck,
    input  logic                     tms,
    input  logic                     tdi,
    input  logic                     trstn,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [3:0]               tap_state,
    output logic [IR_WIDTH-1:0]      ir,
    input  logic [USER_DR_WIDTH-1:0] user_capture_data,
    output logic [USER_DR_WIDTH-1:0] user_update_data,
    output logic                     user_update
);

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(2);

    tap_t                     state, state_nxt;
    logic [1:0]               tck_s, tms_s, tdi_s, trstn_s;
    logic                     tck_d;
    logic                     rise, fall, tms_i, tdi_i, trst;
    logic                     sel_id, sel_user, dr_lsb;
    logic [IR_WIDTH-1:0]      ir_sr;
    logic [31:0]              id_sr;
    logic [USER_DR_WIDTH-1:0] user_sr;
    logic                     bp_sr;

    // Two-flop synchronizers plus one extra tck copy for edge detection.
    // rise and fall both need tck_s[1] != tck_d with opposite polarity,
    // so they can never be asserted together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tck_s   <= '0;
            tms_s   <= '0;
            tdi_s   <= '0;
            trstn_s <= '0;
            tck_d   <= 1'b0;
        end else begin
            tck_s   <= {tck_s[0], tck};
            tms_s   <= {tms_s[0], tms};
            tdi_s   <= {tdi_s[0], tdi};
            trstn_s <= {trstn_s[0], trstn};
            tck_d   <= tck_s[1];
        end
    end

    assign rise      = tck_s[1] & ~tck_d;
    assign fall      = ~tck_s[1] & tck_d;
    assign tms_i     = tms_s[1];
    assign tdi_i     = tdi_s[1];
    assign trst      = ~trstn_s[1];
    assign tap_state = state;
    assign sel_id    = ir == IR_IDCODE;
    assign sel_user  = ir == IR_USER;
    assign dr_lsb    = sel_id ? id_sr[0] : sel_user ? user_sr[0] : bp_sr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= TLR;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (trst)
            state_nxt = TLR;
        else if (rise) begin
            case (state)
                TLR:      state_nxt = tms_i ? TLR    : RTI;
                RTI:      state_nxt = tms_i ? SEL_DR : RTI;
                SEL_DR:   state_nxt = tms_i ? SEL_IR : CAP_DR;
                CAP_DR:   state_nxt = tms_i ? EX1_DR : SH_DR;
                SH_DR:    state_nxt = tms_i ? EX1_DR : SH_DR;
                EX1_DR:   state_nxt = tms_i ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_nxt = tms_i ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_nxt = tms_i ? UPD_DR : SH_DR;
                UPD_DR:   state_nxt = tms_i ? SEL_DR : RTI;
                SEL_IR:   state_nxt = tms_i ? TLR    : CAP_IR;
                CAP_IR:   state_nxt = tms_i ? EX1_IR : SH_IR;
                SH_IR:    state_nxt = tms_i ? EX1_IR : SH_IR;
                EX1_IR:   state_nxt = tms_i ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_nxt = tms_i ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_nxt = tms_i ? UPD_IR : SH_IR;
                UPD_IR:   state_nxt = tms_i ? SEL_DR : RTI;
                default:  state_nxt = TLR;
            endcase
        end
    end

    // Shift registers act on tck rise; outputs and instruction update act on tck fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir               <= IR_IDCODE;
            ir_sr            <= '0;
            id_sr            <= '0;
            user_sr          <= '0;
            bp_sr            <= 1'b0;
            tdo              <= 1'b0;
            tdo_en           <= 1'b0;
            user_update      <= 1'b0;
            user_update_data <= '0;
        end else begin
            user_update <= 1'b0;
            if (trst) begin
                ir      <= IR_IDCODE;
                ir_sr   <= '0;
                id_sr   <= '0;
                user_sr <= '0;
                bp_sr   <= 1'b0;
                tdo_en  <= 1'b0;
            end else if (rise) begin
                // Entering TLR lands the instruction in the same clk as the state change.
                if (state_nxt == TLR)
                    ir <= IR_IDCODE;
                if (state == CAP_IR)
                    ir_sr <= IR_WIDTH'(1);
                if (state == SH_IR)
                    ir_sr <= {tdi_i, ir_sr[IR_WIDTH-1:1]};
                if (state == CAP_DR) begin
                    if (sel_id)
                        id_sr <= IDCODE;
                    else if (sel_user)
                        user_sr <= user_capture_data;
                    else
                        bp_sr <= 1'b0;
                end
                if (state == SH_DR) begin
                    if (sel_id)
                        id_sr <= {tdi_i, id_sr[31:1]};
                    else if (sel_user)
                        user_sr <= {tdi_i, user_sr[USER_DR_WIDTH-1:1]};
                    else
                        bp_sr <= tdi_i;
                end
            end else if (fall) begin
                tdo_en <= state == SH_IR || state == SH_DR;
                if (state == SH_IR)
                    tdo <= ir_sr[0];
                if (state == SH_DR)
                    tdo <= dr_lsb;
                if (state == UPD_IR)
                    ir <= ir_sr;
                if (state == UPD_DR && sel_user) begin
                    user_update_data <= user_sr;
                    user_update      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed self-checking bench for jtag_tap_ctrl
module tb_jtag_tap_ctrl;

    logic        clk = 1'b0;
    logic        rstn, tck, tms, tdi, trstn;
    logic        tdo, tdo_en, user_update;
    logic [3:0]  tap_state;
    logic [4:0]  ir;
    logic [31:0] user_capture_data, user_update_data;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;

    logic       walk_tms [44] = '{1,0,0,1,0,1,0,0,1,0,0,1,1,1,0,0,1,0,1,1,0,1,1,0,1,0,0,1,0,0,1,1,1,1,0,0,1,0,1,1,0,1,1,1};
    logic [3:0] walk_st  [44] = '{4'hF,4'hC,4'hC,4'h7,4'h6,4'h1,4'h3,4'h3,4'h0,4'h2,4'h2,4'h1,4'h5,4'h7,4'h6,4'h2,4'h1,4'h3,4'h0,4'h5,4'hC,4'h7,4'h4,4'hE,4'h9,4'hB,4'hB,4'h8,4'hA,4'hA,4'h9,4'hD,4'h7,4'h4,4'hE,4'hA,4'h9,4'hB,4'h8,4'hD,4'hC,4'h7,4'h4,4'hF};

    jtag_tap_ctrl dut (
        .clk(clk),
        .rstn(rstn),
        .tck(tck),
        .tms(tms),
        .tdi(tdi),
        .trstn(trstn),
        .tdo(tdo),
        .tdo_en(tdo_en),
        .tap_state(tap_state),
        .ir(ir),
        .user_capture_data(user_capture_data),
        .user_update_data(user_update_data),
        .user_update(user_update)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (user_update) upd_cnt++;

    // One full tck period; o is the tdo value the probe samples at this rise.
    task automatic tck_pulse(input logic m, input logic d, output logic o);
        tms = m;
        tdi = d;
        o = tdo;
        repeat (4) @(negedge clk);
        tck = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
        logic o;
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            tck_pulse(i == 4, din[i], o);
            dout[i] = o;
        end
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic o;
        dout = '0;
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        for (int i = 0; i < n; i++) begin
            tck_pulse(i == n - 1, din[i], o);
            dout[i] = o;
        end
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL reset_state: got %h expected f", tap_state); end
        checks++; if (ir !== 5'h01) begin errors++; $display("FAIL reset_ir: got %h expected 01", ir); end
        checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo: got tdo=%b en=%b expected 0 0", tdo, tdo_en); end
        checks++; if (user_update !== 1'b0 || user_update_data !== 32'h0) begin errors++; $display("FAIL reset_user: got upd=%b data=%h expected 0 0", user_update, user_update_data); end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_idcode();
        logic o;
        logic [31:0] seq;
        for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, o);
        checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL tlr_after_5: got %h expected f", tap_state); end
        tck_pulse(1'b0, 1'b0, o);
        checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL rti: got %h expected c", tap_state); end
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        checks++; if (tap_state !== 4'h2 || tdo_en !== 1'b1) begin errors++; $display("FAIL shdr_entry: got state=%h en=%b expected 2 1", tap_state, tdo_en); end
        for (int i = 0; i < 32; i++) begin
            tck_pulse(i == 31, 1'b0, o);
            seq[i] = o;
        end
        checks++; if (seq !== 32'h1DC0_0001) begin errors++; $display("FAIL idcode_seq: got %h expected 1dc00001", seq); end
        checks++; if (tap_state !== 4'h1 || tdo_en !== 1'b0) begin errors++; $display("FAIL ex1dr: got state=%h en=%b expected 1 0", tap_state, tdo_en); end
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL back_rti: got %h expected c", tap_state); end
    endtask

    task automatic test_user();
        logic [4:0] io;
        logic [31:0] dout;
        int base;
        shift_ir(5'h02, io);
        checks++; if (io[1:0] !== 2'b01) begin errors++; $display("FAIL ir_capture: got bits %b expected 01", io[1:0]); end
        checks++; if (ir !== 5'h02) begin errors++; $display("FAIL ir_user: got %h expected 02", ir); end
        user_capture_data = 32'hA5A5_0F0F;
        base = upd_cnt;
        shift_dr(32, 32'h1234_5678, dout);
        checks++; if (dout !== 32'hA5A5_0F0F) begin errors++; $display("FAIL user_tdo: got %h expected a5a50f0f", dout); end
        checks++; if (user_update_data !== 32'h1234_5678) begin errors++; $display("FAIL user_data: got %h expected 12345678", user_update_data); end
        checks++; if (upd_cnt - base !== 1) begin errors++; $display("FAIL user_pulse: got %0d expected 1", upd_cnt - base); end
    endtask

    task automatic test_bypass();
        logic [4:0] io;
        logic [31:0] dout;
        int base;
        base = upd_cnt;
        shift_ir(5'h1F, io);
        checks++; if (ir !== 5'h1F) begin errors++; $display("FAIL ir_bypass: got %h expected 1f", ir); end
        shift_dr(8, 32'h0000_00C3, dout);
        checks++; if (dout[7:0] !== 8'h86) begin errors++; $display("FAIL bypass_c3: got %h expected 86", dout[7:0]); end
        shift_ir(5'h03, io);
        shift_dr(4, 32'h0000_000A, dout);
        checks++; if (dout[3:0] !== 4'h4) begin errors++; $display("FAIL bypass_other: got %h expected 4", dout[3:0]); end
        checks++; if (upd_cnt - base !== 0 || user_update_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_side: got pulses=%0d data=%h expected 0 12345678", upd_cnt - base, user_update_data); end
    endtask

    task automatic test_trst();
        logic o;
        logic [4:0] io;
        int base;
        shift_ir(5'h02, io);
        base = upd_cnt;
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        for (int i = 0; i < 3; i++) tck_pulse(1'b0, 1'b1, o);
        checks++; if (tap_state !== 4'h2 || tdo_en !== 1'b1) begin errors++; $display("FAIL trst_pre: got state=%h en=%b expected 2 1", tap_state, tdo_en); end
        trstn = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (tap_state !== 4'hF || ir !== 5'h01 || tdo_en !== 1'b0) begin errors++; $display("FAIL trst_force: got state=%h ir=%h en=%b expected f 01 0", tap_state, ir, tdo_en); end
        trstn = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (user_update_data !== 32'h1234_5678 || upd_cnt - base !== 0) begin errors++; $display("FAIL trst_retain: got data=%h pulses=%0d expected 12345678 0", user_update_data, upd_cnt - base); end
    endtask

    task automatic test_walk();
        logic o;
        int bad = 0;
        for (int i = 0; i < 44; i++) begin
            tck_pulse(walk_tms[i], 1'b0, o);
            checks++;
            if (tap_state !== walk_st[i]) begin
                errors++;
                bad++;
                $display("FAIL walk_%0d: got %h expected %h", i, tap_state, walk_st[i]);
            end
        end
    endtask

    task automatic test_tlr();
        logic o;
        tck_pulse(1'b0, 1'b0, o);
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        tck_pulse(1'b0, 1'b1, o);
        checks++; if (tap_state !== 4'hA) begin errors++; $display("FAIL shir_reach: got %h expected a", tap_state); end
        for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b1, o);
        checks++; if (tap_state !== 4'hF || ir !== 5'h01) begin errors++; $display("FAIL tlr_from_shir: got state=%h ir=%h expected f 01", tap_state, ir); end
    endtask

    task automatic test_async_reset();
        logic o;
        logic [4:0] io;
        int base;
        tck_pulse(1'b0, 1'b0, o);
        shift_ir(5'h02, io);
        user_capture_data = 32'h0BAD_F00D;
        tck_pulse(1'b1, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        tck_pulse(1'b0, 1'b0, o);
        tck_pulse(1'b0, 1'b1, o);
        tck_pulse(1'b1, 1'b1, o);
        base = upd_cnt;
        tms = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (tap_state !== 4'h5) begin errors++; $display("FAIL upd_dr_reach: got %h expected 5", tap_state); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (tap_state !== 4'hF || ir !== 5'h01 || tdo !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL async_state: got state=%h ir=%h tdo=%b en=%b expected f 01 0 0", tap_state, ir, tdo, tdo_en); end
        checks++; if (user_update_data !== 32'h0 || user_update !== 1'b0) begin errors++; $display("FAIL async_user: got data=%h upd=%b expected 0 0", user_update_data, user_update); end
        tck = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (upd_cnt - base !== 0 || user_update_data !== 32'h0 || tap_state !== 4'hF) begin errors++; $display("FAIL async_after: got pulses=%0d data=%h state=%h expected 0 0 f", upd_cnt - base, user_update_data, tap_state); end
    endtask

    initial begin
        rstn = 1'b0;
        tck = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        trstn = 1'b1;
        user_capture_data = '0;
        test_reset();
        test_idcode();
        test_user();
        test_bypass();
        test_trst();
        test_walk();
        test_tlr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5, instruction register width (min 2).
REQ-002 SHALL have parameter IDCODE, default 32'h1DC0_0001, IDCODE DR value (bit0 must be 1).
REQ-003 SHALL have parameter USER_DR_WIDTH, default 32, user data register width (min 2).
REQ-004 SHALL have port clk  input  1  system clock that oversamples all JTAG pins.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports tck, tms, tdi, trstn  input  1 each  JTAG pins from probe, asynchronous to clk.
REQ-007 SHALL have port tdo  output  1  test data out.
REQ-008 SHALL have port tdo_en  output  1  high while tdo carries shift data.
REQ-009 SHALL have port tap_state  output  4  current TAP state, IEEE 1149.1 encoding.
REQ-010 SHALL have port ir  output  IR_WIDTH  current instruction.
REQ-011 SHALL have port user_capture_data  input  USER_DR_WIDTH  value loaded into user DR on Capture-DR.
REQ-012 SHALL have port user_update_data  output  USER_DR_WIDTH  user DR value latched on Update-DR.
REQ-013 SHALL have port user_update  output  1  one-clk pulse when user_update_data changes.

Function
REQ-014 SHALL pass tck, tms, tdi, trstn through 2-flop synchronizers in clk; tck rise/fall SHALL be detected by comparing synced tck with one more registered copy.
REQ-015 SHALL act only on detected edges; a tck pin edge SHALL take effect 3 clk cycles after it reaches the pin.
REQ-016 SHALL run a 16-state TAP FSM advanced on tck rise by synced tms, encoding TLR=F RTI=C SelDR=7 CapDR=6 ShDR=2 Ex1DR=1 PauseDR=3 Ex2DR=0 UpdDR=5 SelIR=4 CapIR=E ShIR=A Ex1IR=9 PauseIR=B Ex2IR=8 UpdIR=D, transitions per IEEE 1149.1.
REQ-017 SHALL reach TLR after 5 consecutive tck rises with tms=1 from any state.
REQ-018 Instructions: all-ones = BYPASS; 1 = IDCODE; 2 = USER; any other = BYPASS.
REQ-019 On tck rise while in CapIR: IR shift reg SHALL load {0..0,01}; in CapDR: selected DR loads (IDCODE, user_capture_data, or 0 for BYPASS).
REQ-020 On tck rise while in ShIR/ShDR: selected shift reg SHALL shift right, tdi into MSB, LSB out.
REQ-021 On tck fall while in ShIR/ShDR: tdo SHALL register shift reg LSB and tdo_en go 1; on tck fall in any other state tdo_en SHALL go 0 and tdo hold.
REQ-022 On tck fall while in UpdIR: ir SHALL load IR shift reg.
REQ-023 On tck fall while in UpdDR with ir=USER: user_update_data SHALL load user shift reg and user_update SHALL pulse for exactly 1 clk.
REQ-024 IDCODE and BYPASS Update-DR SHALL have no side effects.
REQ-025 Rise and fall detected in the same clk (glitch) SHALL be impossible by construction; a tck pulse shorter than 1 clk MAY be missed and SHALL NOT corrupt state.
REQ-026 tap_state and ir SHALL be registered outputs; user_update SHALL be registered.

Reset
REQ-027 rstn low SHALL asynchronously set: tap_state=F, ir=IDCODE instr (1), tdo=0, tdo_en=0, user_update=0, user_update_data=0, shift regs=0, synchronizer flops=0 except trstn chain=0.
REQ-028 Synced trstn=0 SHALL synchronously force tap_state=F, ir=1, tdo_en=0 while low; user_update_data SHALL be retained.
REQ-029 Entering TLR by tms SHALL set ir=1 on the same clk as the state change.
REQ-030 Reset mid-shift SHALL discard partial shift contents; no user_update pulse SHALL be produced.

Verification
REQ-031 Reset, 5 tck with tms=1, TLR->RTI->SelDR->CapDR->ShDR, shift 32 bits -> tdo sequence = 32'h1DC0_0001 LSB first.
REQ-032 Shift IR=2 (USER), user_capture_data=32'hA5A5_0F0F, shift in 32'h1234_5678 then UpdDR -> tdo out 32'hA5A5_0F0F, user_update_data=32'h1234_5678, single user_update pulse.
REQ-033 IR=5'h1F, shift 8 bits 8'hC3 through DR -> tdo = 0 then 8'hC3 delayed 1 bit.
REQ-034 Pulse trstn low for 4 clk while in ShDR -> tap_state=F, ir=1, tdo_en=0, user_update never asserted.
REQ-035 ShIR, capture then shift 5 bits -> first two tdo bits 1,0; tap_state tracks all 16 states via a tms walk hitting every transition.
REQ-036 Assert rstn low asynchronously mid-Update-DR -> outputs at reset values immediately, no user_update pulse.
